// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and helpers for the fetch PC unit and its branch target buffer.
package fetch_pkg;

  // Widest PC the BTB entry format can hold; narrower PCs are zero-extended.
  localparam int unsigned XLEN = 64;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic            valid;
    ctr_e            ctr;
    logic [XLEN-1:0] tag;
    logic [XLEN-1:0] target;
  } btb_entry_t;

  function automatic ctr_e ctr_sat_inc(input ctr_e c);
    case (c)
      CTR_SNT: ctr_sat_inc = CTR_WNT;
      CTR_WNT: ctr_sat_inc = CTR_WT;
      default: ctr_sat_inc = CTR_ST;
    endcase
  endfunction

  function automatic ctr_e ctr_sat_dec(input ctr_e c);
    case (c)
      CTR_ST:  ctr_sat_dec = CTR_WT;
      CTR_WT:  ctr_sat_dec = CTR_WNT;
      default: ctr_sat_dec = CTR_SNT;
    endcase
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: hazard/execute controls in, fetch PC and prediction out.
interface fetch_pc_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  stall_f;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  btb_upd_valid;
  logic [DATA_WIDTH-1:0] btb_upd_pc;
  logic [DATA_WIDTH-1:0] btb_upd_target;
  logic                  btb_upd_taken;
  logic [DATA_WIDTH-1:0] pc;
  logic                  pred_taken;
  logic [DATA_WIDTH-1:0] pred_target;
  logic                  misalign_trap;

  modport master (
    output stall_f, redirect_valid, redirect_pc,
    output btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
    input  pc, pred_taken, pred_target, misalign_trap
  );

  modport slave (
    input  stall_f, redirect_valid, redirect_pc,
    input  btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
    output pc, pred_taken, pred_target, misalign_trap
  );
endinterface

// File: rtl/fetch_pc_unit_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BTB_ENTRIES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  hit_o,
  output logic                  taken_o,
  output logic [DATA_WIDTH-1:0] target_o,
  input  logic                  upd_valid_i,
  input  logic [DATA_WIDTH-1:0] upd_pc_i,
  input  logic [DATA_WIDTH-1:0] upd_target_i,
  input  logic                  upd_taken_i
);
  localparam int unsigned IDX = $clog2(BTB_ENTRIES);

  btb_entry_t mem_q [BTB_ENTRIES];

  logic [IDX-1:0] lk_idx;
  btb_entry_t     lk_e;
  logic [IDX-1:0] upd_idx;
  btb_entry_t     upd_old;
  btb_entry_t     upd_d;
  logic           upd_hit;
  logic           upd_we;

  always_comb begin
    lk_idx   = pc_i[IDX+1:2];
    lk_e     = mem_q[lk_idx];
    hit_o    = lk_e.valid && (lk_e.tag == XLEN'(pc_i >> (IDX + 2)));
    taken_o  = hit_o && lk_e.ctr[1];
    target_o = hit_o ? DATA_WIDTH'(lk_e.target) : '0;
  end

  always_comb begin
    upd_idx = upd_pc_i[IDX+1:2];
    upd_old = mem_q[upd_idx];
    upd_hit = upd_old.valid && (upd_old.tag == XLEN'(upd_pc_i >> (IDX + 2)));
    upd_d   = upd_old;
    upd_we  = 1'b0;
    if (upd_valid_i) begin
      if (upd_taken_i) begin
        upd_we        = 1'b1;
        upd_d.target  = XLEN'(upd_target_i);
        if (upd_hit) begin
          upd_d.ctr   = ctr_sat_inc(upd_old.ctr);
        end else begin
          upd_d.valid = 1'b1;
          upd_d.tag   = XLEN'(upd_pc_i >> (IDX + 2));
          upd_d.ctr   = CTR_WT;
        end
      end else if (upd_hit) begin
        upd_we    = 1'b1;
        upd_d.ctr = ctr_sat_dec(upd_old.ctr);
      end
    end
  end

  // Lookup reads mem_q combinationally, so a same-cycle update is only seen next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        mem_q[IDX'(i)] <= '0;
      end
    end else if (upd_we) begin
      mem_q[upd_idx] <= upd_d;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register with redirect/stall/prediction priority and misaligned-target trap.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0010,
  parameter int unsigned           BTB_ENTRIES  = 8
) (
  input  logic           clk,
  input  logic           rst,
  fetch_pc_unit_if.slave bus
);
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  trap_q, trap_d;
  logic [DATA_WIDTH-1:0] redir_t;
  logic                  btb_hit;
  logic                  btb_taken;
  logic [DATA_WIDTH-1:0] btb_target;

  fetch_btb #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_q),
    .hit_o        (btb_hit),
    .taken_o      (btb_taken),
    .target_o     (btb_target),
    .upd_valid_i  (bus.btb_upd_valid),
    .upd_pc_i     (bus.btb_upd_pc),
    .upd_target_i (bus.btb_upd_target),
    .upd_taken_i  (bus.btb_upd_taken)
  );

  always_comb begin
    redir_t = bus.redirect_pc & ~DATA_WIDTH'(1);
    pc_d    = pc_q + DATA_WIDTH'(4);
    trap_d  = 1'b0;
    if (bus.redirect_valid) begin
      if (redir_t[1]) begin
        pc_d   = TRAP_VECTOR;
        trap_d = 1'b1;
      end else begin
        pc_d   = redir_t;
      end
    end else if (bus.stall_f) begin
      pc_d = pc_q;
    end else if (btb_taken) begin
      pc_d = btb_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_VECTOR;
      trap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      trap_q <= trap_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pred_taken    = btb_taken;
  assign bus.pred_target   = btb_target;
  assign bus.misalign_trap = trap_q;

  logic unused_hit;
  assign unused_hit = btb_hit;

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Parametrised fetch-stage program-counter generator for the pipelined core. It owns the PC register and applies hazard stalls and execute-stage redirects. It predicts taken branches and jumps with a small direct-mapped branch target buffer (BTB) that uses 2-bit saturating counters, and it traps misaligned redirect targets to a fixed vector. It sits between the hazard unit, the execute stage, and the instruction memory address port.

## Interface
- `DATA_WIDTH`, 32: PC and target width.
- `RESET_VECTOR`, 32'h0000_0000: PC value loaded by reset.
- `TRAP_VECTOR`, 32'h0000_0010: PC value loaded on a misaligned redirect.
- `BTB_ENTRIES`, 8: number of BTB entries; power of two, at least 2. `IDX = $clog2(BTB_ENTRIES)`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall_f` in 1: hold the PC (hazard unit).
- `redirect_valid` in 1: execute stage corrects the fetch path.
- `redirect_pc` in DATA_WIDTH: corrected target (branch, JAL or JALR result).
- `btb_upd_valid` in 1: resolved control-flow instruction in execute.
- `btb_upd_pc` in DATA_WIDTH: PC of that instruction.
- `btb_upd_target` in DATA_WIDTH: its resolved target.
- `btb_upd_taken` in 1: 1 if the instruction was taken.
- `pc` out DATA_WIDTH: current fetch PC, registered.
- `pred_taken` out 1: BTB hit on `pc` with counter bit[1] set; combinational.
- `pred_target` out DATA_WIDTH: target of the BTB entry that hit; 0 when no hit.
- `misalign_trap` out 1: registered one-cycle pulse that marks a trap redirect.

## Operation
- BTB entry fields: `valid`, `tag = pc[DATA_WIDTH-1:IDX+2]`, `target`, `ctr[1:0]`. Index is `pc[IDX+1:2]`.
- Hit: the indexed entry is valid and its tag equals the tag of `pc`.
- Next-PC priority, highest first:
  1. `rst`: load RESET_VECTOR.
  2. `redirect_valid`: let `t = {redirect_pc[W-1:1],1'b0}`. If `t[1]` is 1, load TRAP_VECTOR and set `misalign_trap`. Otherwise load `t`.
  3. `stall_f`: hold `pc`.
  4. `pred_taken`: load `pred_target`.
  5. Otherwise load `pc + 4`, modulo 2^DATA_WIDTH, so 32'hFFFF_FFFC wraps to 0.
- A redirect overrides a stall. A redirect taken during a stall is not lost.
- BTB update, applied when `btb_upd_valid` is high and the entry addressed by `btb_upd_pc` is looked up:
  - taken and hit: saturating increment of `ctr` (max 3); overwrite `target`.
  - taken and miss: allocate the entry, replacing any occupant. Set `valid=1`, write the tag and target, set `ctr=2'b10`.
  - not taken and hit: saturating decrement of `ctr` (min 0). The entry stays valid.
  - not taken and miss: no change.
- BTB updates proceed regardless of `stall_f` and `redirect_valid`.
- Reset clears every `valid` bit and every `ctr` to 0. A reset mid-operation discards all prediction state.

## Timing
- Reset values: `pc` = RESET_VECTOR, `misalign_trap` = 0, `pred_taken` = 0, `pred_target` = 0. All BTB entries are invalid after reset, which is why `pred_taken` and `pred_target` read 0.
- `pc` changes only at a clock edge. Redirect latency is 1 cycle: `redirect_pc` is sampled at edge N and appears on `pc` after edge N.
- `misalign_trap` is high for exactly the cycle in which `pc` equals TRAP_VECTOR because of that trap.
- Lookup is read-before-write. An update at edge N is visible to a lookup after edge N, never in the same cycle. If an update and a lookup hit the same index in one cycle, the prediction uses the old entry.
- `pred_taken` and `pred_target` are purely combinational from `pc` and BTB state. There is no input-to-output combinational path.

## Structure
- Shared package `fetch_pkg`:
  - `btb_entry_t` packed struct.
  - Counter constants: `CTR_SNT=2'b00`, `CTR_WNT=2'b01`, `CTR_WT=2'b10`, `CTR_ST=2'b11`.
  - Saturating increment and decrement functions.
- Sub-module `fetch_btb`:
  - Entry storage, lookup and update logic.
  - Parameters DATA_WIDTH and BTB_ENTRIES.
  - Lookup port: pc in; hit, taken, target out.
  - Update port: the `btb_upd_*` signals.
- Top level keeps the PC register, the next-PC priority mux and the trap flag.

## Test plan
- Reset and sequential fetch: release `rst` with no other input. Expect `pc` = 0, 4, 8, 12. With the PC forced to 32'hFFFF_FFFC and no other input, the next `pc` is 0.
- Stall then redirect: hold `stall_f=1` for 3 cycles and expect `pc` to stay at 8. Then assert `redirect_valid` with `redirect_pc=32'h40` while `stall_f=1`. Expect `pc=32'h40` next cycle and `misalign_trap=0`.
- JALR LSB and misalignment: `redirect_pc=32'h81` gives `pc=32'h80`. `redirect_pc=32'h82` gives `pc=TRAP_VECTOR` (32'h10) with `misalign_trap` high for 1 cycle.
- BTB training: one taken update for PC 32'h20 with target 32'h100 sets `ctr=10`. On the next fetch of 32'h20, `pred_taken=1` and the following `pc` is 32'h100. Two not-taken updates bring `ctr` to 00, after which a fetch of 32'h20 gives `pred_taken=0` and next `pc` 32'h24.
- Aliasing and saturation, with BTB_ENTRIES=8:
  - Allocate PC 32'h20, then a taken update for PC 32'h40 (same index): 32'h20 now misses.
  - Four taken updates hold `ctr` at 11.
  - A not-taken update for a missing PC changes no entry.
- Same-cycle update and reset: an update during a lookup of the same index gives a prediction from the old entry. Asserting `rst` mid-run makes every later lookup miss and restores `pc=RESET_VECTOR`.
